// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and types for the ram block.
//   RAM_DATA_WIDTH : default memory word width in bits
//   RAM_ADDR_WIDTH : default address width in bits
//   RAM_DEPTH      : number of words at the default address width
//   addr_t, data_t : address and word types at the default widths
// The collision behaviour of ram is selected by macro RAM_WRITE_BYPASS_EN
// (see rtl/ram.sv); nothing in this package depends on it.
package ram_pkg;

  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 4;
  localparam int RAM_DEPTH      = 2 ** RAM_ADDR_WIDTH;

  typedef logic [RAM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [RAM_DATA_WIDTH-1:0] data_t;

  // True when a write and a read in the same edge hit the same word.
  function automatic logic is_collision(input logic we, input logic re,
                                        input addr_t wa, input addr_t ra);
    return we & re & (wa == ra);
  endfunction

endpackage

// File: rtl/ram_intf.sv
// intf: bundle of the ram signals for bench or system wiring.
//   clk, rst (ports)  : clock and asynchronous active-low reset
//   enb, wr, rd       : enable and access requests
//   w_addr, r_addr    : write / read addresses
//   w_data, r_data    : write data / registered read data
interface intf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic clk,
  input logic rst
);

  logic                  enb;
  logic                  wr;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0] r_data;

  modport master (input clk, input rst, output enb, output wr, output rd,
                  output w_addr, output r_addr, output w_data, input r_data);
  modport slave  (input clk, input rst, input enb, input wr, input rd,
                  input w_addr, input r_addr, input w_data, output r_data);

endinterface

// File: rtl/ram_mem_array.sv
// ram_mem_array: storage array with one synchronous write port, one
// combinational read port and an asynchronous clear of every word.
//   clk    : clock, writes on rising edge
//   rst    : asynchronous active-low clear of all words
//   we     : write enable (already gated by the caller)
//   w_addr : write address
//   w_data : write data
//   r_addr : read address
//   r_word : combinational contents of mem[r_addr]
module ram_mem_array
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_word
);

  localparam int DEPTH_L = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH_L];

  // Word storage: cleared asynchronously, written on enabled edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_L; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (we) begin
      mem_r[w_addr] <= w_data;
    end
  end

  // Full 2**ADDR_WIDTH depth, so every address is in range.
  assign r_word = mem_r[r_addr];

endmodule

// File: rtl/ram.sv
// ram: single-clock two-port RAM with registered read data.
//   clk    : clock, all state changes on rising edge
//   rst    : asynchronous active-low reset (clears r_data and memory)
//   enb    : block enable; wr/rd ignored while low
//   wr, rd : write / read requests
//   w_addr : write address      w_data : write data
//   r_addr : read address       r_data : read data, one-cycle latency
// Macro RAM_WRITE_BYPASS_EN: when defined, a same-address write+read
// returns the new w_data (write-first); otherwise the old word
// (read-first). The memory takes w_data in both builds.
module ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic                  we_s;
  logic                  re_s;
  logic                  collision_s;
  logic [DATA_WIDTH-1:0] arr_word_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] r_data_r;

  // Enable gating: an X on wr/rd is masked to 0 while enb is low.
  assign we_s        = enb & wr;
  assign re_s        = enb & rd;
  assign collision_s = we_s & re_s & (w_addr == r_addr);

  ram_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .we     (we_s),
    .w_addr (w_addr),
    .w_data (w_data),
    .r_addr (r_addr),
    .r_word (arr_word_s)
  );

  // Read-data source: array word, or new write data on a bypassed collision.
  always_comb begin
    rd_word_s = arr_word_s;
`ifdef RAM_WRITE_BYPASS_EN
    if (collision_s) begin
      rd_word_s = w_data;
    end else begin
      rd_word_s = arr_word_s;
    end
`else
    // The array still holds the old word at this edge: read-first.
    if (collision_s) begin
      rd_word_s = arr_word_s;
    end else begin
      rd_word_s = arr_word_s;
    end
`endif
  end

  // Read register: cleared at once by reset, loaded only on enabled reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_r <= {DATA_WIDTH{1'b0}};
    end else if (re_s) begin
      r_data_r <= rd_word_s;
    end else begin
      r_data_r <= r_data_r;
    end
  end

  assign r_data = r_data_r;

endmodule

// File: tb/tb_ram.sv
// tb_ram: directed self-checking bench for ram. A reference memory model
// checks r_data on every falling edge; directed scenarios add literal
// expectations. Honours RAM_WRITE_BYPASS_EN for the collision result.
module tb_ram;

  logic clk;
  logic rst;

  int checks;
  int errors;
  bit check_en;

`ifdef RAM_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  intf #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus (.clk(clk), .rst(rst));

  ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .enb    (bus.enb),
    .wr     (bus.wr),
    .rd     (bus.rd),
    .w_addr (bus.w_addr),
    .r_addr (bus.r_addr),
    .w_data (bus.w_data),
    .r_data (bus.r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain array and the read register it feeds.
  logic [7:0] m_mem [16];
  logic [7:0] m_rd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] <= 8'h00;
      m_rd <= 8'h00;
    end else if (bus.enb === 1'b1) begin
      if (bus.rd === 1'b1) begin
        if (BYPASS && bus.wr === 1'b1 && bus.w_addr == bus.r_addr)
          m_rd <= bus.w_data;
        else
          m_rd <= m_mem[bus.r_addr];
      end
      if (bus.wr === 1'b1) m_mem[bus.w_addr] <= bus.w_data;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    if (check_en && rst === 1'b1) chk("model", bus.r_data, m_rd);
  end

  task automatic step(input logic e, input logic w, input logic r,
                      input logic [3:0] wa, input logic [3:0] ra,
                      input logic [7:0] wd);
    @(negedge clk);
    bus.enb    = e;
    bus.wr     = w;
    bus.rd     = r;
    bus.w_addr = wa;
    bus.r_addr = ra;
    bus.w_data = wd;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    check_en = 1'b0;
    rst      = 1'b1;
    bus.enb = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
    bus.w_addr = 4'h0; bus.r_addr = 4'h0; bus.w_data = 8'h00;
    #1 rst = 1'b0;
    #2 chk("reset_rdata", bus.r_data, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;

    // Every address reads back zero after reset.
    for (int a = 0; a < 16; a++) begin
      step(1'b1, 1'b0, 1'b1, 4'h0, 4'(a), 8'h00);
      idle();
      chk("reset_read", bus.r_data, 8'h00);
    end

    // Basic write then read.
    step(1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 8'hA5);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd3, 8'h00);
    idle();
    chk("wr_rd_3", bus.r_data, 8'hA5);

    // Disabled write, with r_data held while enb is low.
    step(1'b0, 1'b1, 1'b1, 4'd5, 4'd0, 8'h3C);
    @(negedge clk);
    bus.enb = 1'b0; bus.wr = 1'bx; bus.rd = 1'bx;
    bus.w_addr = 4'bxxxx; bus.r_addr = 4'bxxxx; bus.w_data = 8'hxx;
    idle();
    chk("enb_hold", bus.r_data, 8'hA5);
    // Enabled write without rd must not disturb r_data.
    step(1'b1, 1'b1, 1'b0, 4'd6, 4'd0, 8'h77);
    idle();
    chk("rd0_hold", bus.r_data, 8'hA5);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 8'h00);
    idle();
    chk("enb_gate_5", bus.r_data, 8'h00);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd6, 8'h00);
    idle();
    chk("rd_6", bus.r_data, 8'h77);

    // Simultaneous write and read at different addresses.
    step(1'b1, 1'b1, 1'b1, 4'd8, 4'd3, 8'h5A);
    idle();
    chk("dual_rd_3", bus.r_data, 8'hA5);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd8, 8'h00);
    idle();
    chk("dual_wr_8", bus.r_data, 8'h5A);

    // Same-address collision.
    step(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 8'h11);
    step(1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 8'h22);
    idle();
`ifdef RAM_WRITE_BYPASS_EN
    chk("collision", bus.r_data, 8'h22);
`else
    chk("collision", bus.r_data, 8'h11);
`endif
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 8'h00);
    idle();
    chk("collision_mem", bus.r_data, 8'h22);

    // Boundary addresses.
    step(1'b1, 1'b1, 1'b0, 4'd15, 4'd0, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 8'h01);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd15, 8'h00);
    idle();
    chk("rd_15", bus.r_data, 8'hFF);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 8'h00);
    idle();
    chk("rd_0", bus.r_data, 8'h01);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd15, 8'h00);
    idle();
    chk("rd_15_again", bus.r_data, 8'hFF);

    // Reset asserted mid-cycle: r_data clears at once, pending write dropped.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("midrst_rdata", bus.r_data, 8'h00);
    step(1'b1, 1'b1, 1'b1, 4'd15, 4'd15, 8'hAA);
    @(negedge clk);
    rst = 1'b1;
    bus.enb = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd15, 8'h00);
    idle();
    chk("midrst_rd_15", bus.r_data, 8'h00);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 8'h00);
    idle();
    chk("midrst_rd_0", bus.r_data, 8'h00);

    idle();
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
